// File: rtl/beam_delay_bank_pkg.sv
// rtl/beam_delay_bank_pkg.sv - shared constants, types and width helper for the beam delay bank
// Purpose: default geometry of the delay bank plus the sample/delay/profile types.
// Ports: none (package).
package beam_pkg;

  localparam int DEF_NUM_CH    = 16;
  localparam int DEF_DATA_W    = 19;
  localparam int DEF_MAX_DELAY = 32;
  localparam int DEF_NUM_STEER = 32;

  // Index width that never collapses to zero bits for single-entry dimensions.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic signed [DEF_DATA_W-1:0]         pcm_t;
  typedef logic [$clog2(DEF_MAX_DELAY)-1:0]     delay_t;
  typedef logic [$clog2(DEF_NUM_STEER)-1:0]     steer_t;
  typedef logic [$clog2(DEF_NUM_CH)-1:0]        ch_t;

endpackage

// File: rtl/beam_delay_bank_if.sv
// rtl/beam_delay_bank_if.sv - sample stream, steering and table-write bundle of the delay bank
// Purpose: groups every non-clock/reset signal of beam_delay_bank.
// Ports (signals): in_valid, pcm_in, steer_sel, cfg_we/cfg_steer/cfg_ch/cfg_delay (master -> slave);
//                  out_valid, pcm_out, active_steer (slave -> master);
//                  sum_out, sum_valid (slave -> master) only when SUM_OUT_EN is defined.
interface beam_delay_bank_if
  import beam_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_DELAY = DEF_MAX_DELAY,
  parameter int NUM_STEER = DEF_NUM_STEER
);
  localparam int CH_W  = idx_w(NUM_CH);
  localparam int DLY_W = idx_w(MAX_DELAY);
  localparam int SEL_W = idx_w(NUM_STEER);
  localparam int SUM_W = DATA_W + $clog2(NUM_CH);

  logic                     in_valid;
  logic [NUM_CH*DATA_W-1:0] pcm_in;
  logic [SEL_W-1:0]         steer_sel;
  logic                     cfg_we;
  logic [SEL_W-1:0]         cfg_steer;
  logic [CH_W-1:0]          cfg_ch;
  logic [DLY_W-1:0]         cfg_delay;
  logic                     out_valid;
  logic [NUM_CH*DATA_W-1:0] pcm_out;
  logic [SEL_W-1:0]         active_steer;
`ifdef SUM_OUT_EN
  logic signed [SUM_W-1:0]  sum_out;
  logic                     sum_valid;

  modport master (
    output in_valid, pcm_in, steer_sel, cfg_we, cfg_steer, cfg_ch, cfg_delay,
    input  out_valid, pcm_out, active_steer, sum_out, sum_valid
  );
  modport slave (
    input  in_valid, pcm_in, steer_sel, cfg_we, cfg_steer, cfg_ch, cfg_delay,
    output out_valid, pcm_out, active_steer, sum_out, sum_valid
  );
`else
  modport master (
    output in_valid, pcm_in, steer_sel, cfg_we, cfg_steer, cfg_ch, cfg_delay,
    input  out_valid, pcm_out, active_steer
  );
  modport slave (
    input  in_valid, pcm_in, steer_sel, cfg_we, cfg_steer, cfg_ch, cfg_delay,
    output out_valid, pcm_out, active_steer
  );
`endif

endinterface

// File: rtl/beam_delay_bank_ram.sv
// rtl/beam_delay_bank_ram.sv - single-channel circular sample buffer
// Purpose: MAX_DELAY-deep sample store for one microphone channel.
// Ports: clk; wr_en/wr_addr/wr_data synchronous write; rd_addr -> rd_data asynchronous read.
module beam_delay_ram
  import beam_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_DELAY = DEF_MAX_DELAY
) (
  input  logic                           clk,
  input  logic                           wr_en,
  input  logic [idx_w(MAX_DELAY)-1:0]    wr_addr,
  input  logic [DATA_W-1:0]              wr_data,
  input  logic [idx_w(MAX_DELAY)-1:0]    rd_addr,
  output logic [DATA_W-1:0]              rd_data
);

  // Contents are deliberately not reset: the bank's fill counter masks stale words.
  logic [DATA_W-1:0] mem_q [MAX_DELAY];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/beam_delay_bank.sv
// rtl/beam_delay_bank.sv - per-channel integer-sample delay bank with steering profile table
// Purpose: delays each channel by the delay of the selected steering profile; profiles are
//          runtime-writable, outputs are masked until enough samples have been accepted.
// Ports: clk, rst (synchronous, active-low); bus (beam_delay_bank_if.slave) carrying the sample
//        stream, steering select, table write port and delayed outputs.
// Config: SUM_OUT_EN adds a registered signed sum of all delayed channels (bus.sum_out/sum_valid).
module beam_delay_bank
  import beam_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_DELAY = DEF_MAX_DELAY,
  parameter int NUM_STEER = DEF_NUM_STEER
) (
  input  logic               clk,
  input  logic               rst,
  beam_delay_bank_if.slave   bus
);

  localparam int DLY_W  = idx_w(MAX_DELAY);
  localparam int SEL_W  = idx_w(NUM_STEER);
  localparam int FILL_W = $clog2(MAX_DELAY + 1);
  localparam logic [DLY_W-1:0]  DLY_MAX  = DLY_W'(MAX_DELAY - 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(MAX_DELAY);

  typedef logic [DLY_W-1:0] dly_t;

  logic [DLY_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0]        fill_cnt_q, fill_cnt_d;
  logic                     out_valid_q, out_valid_d;
  logic [NUM_CH*DATA_W-1:0] pcm_out_q, pcm_out_d;
  logic [SEL_W-1:0]         active_steer_q, active_steer_d;
  dly_t                     table_q [NUM_STEER][NUM_CH];
  dly_t                     table_d [NUM_STEER][NUM_CH];

  dly_t                     cur_dly [NUM_CH];
  logic [DLY_W-1:0]         rd_addr [NUM_CH];
  logic [DATA_W-1:0]        rd_data [NUM_CH];

  // Delays of the profile requested this cycle. The table is read before the edge,
  // so a table write landing on the same edge only affects later samples.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      cur_dly[c] = table_q[bus.steer_sel][c];
      if (cur_dly[c] <= wr_ptr_q) begin
        rd_addr[c] = wr_ptr_q - cur_dly[c];
      end else begin
        rd_addr[c] = DLY_W'(int'(wr_ptr_q) + MAX_DELAY - int'(cur_dly[c]));
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    beam_delay_ram #(
      .DATA_W    (DATA_W),
      .MAX_DELAY (MAX_DELAY)
    ) u_ram (
      .clk     (clk),
      .wr_en   (bus.in_valid),
      .wr_addr (wr_ptr_q),
      .wr_data (bus.pcm_in[g*DATA_W +: DATA_W]),
      .rd_addr (rd_addr[g]),
      .rd_data (rd_data[g])
    );
  end

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    fill_cnt_d     = fill_cnt_q;
    out_valid_d    = bus.in_valid;
    pcm_out_d      = pcm_out_q;
    active_steer_d = active_steer_q;

    if (bus.in_valid) begin
      wr_ptr_d       = (wr_ptr_q == DLY_MAX) ? '0 : wr_ptr_q + 1'b1;
      fill_cnt_d     = (fill_cnt_q == FILL_MAX) ? fill_cnt_q : fill_cnt_q + 1'b1;
      active_steer_d = bus.steer_sel;
      for (int c = 0; c < NUM_CH; c++) begin
        if (cur_dly[c] == '0) begin
          // Zero delay bypasses the RAM: the sample being written is returned.
          pcm_out_d[c*DATA_W +: DATA_W] = bus.pcm_in[c*DATA_W +: DATA_W];
        end else if (int'(cur_dly[c]) > int'(fill_cnt_q)) begin
          // Counting the current sample there are fill_cnt_q+1 valid words;
          // anything older than that is stale RAM content.
          pcm_out_d[c*DATA_W +: DATA_W] = '0;
        end else begin
          pcm_out_d[c*DATA_W +: DATA_W] = rd_data[c];
        end
      end
    end
  end

  always_comb begin
    table_d = table_q;
    if (bus.cfg_we && (int'(bus.cfg_steer) < NUM_STEER) && (int'(bus.cfg_ch) < NUM_CH)) begin
      table_d[bus.cfg_steer][bus.cfg_ch] =
        (int'(bus.cfg_delay) > MAX_DELAY - 1) ? DLY_MAX : bus.cfg_delay;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q       <= '0;
      fill_cnt_q     <= '0;
      out_valid_q    <= 1'b0;
      pcm_out_q      <= '0;
      active_steer_q <= '0;
      for (int s = 0; s < NUM_STEER; s++) begin
        for (int c = 0; c < NUM_CH; c++) begin
          table_q[s][c] <= '0;
        end
      end
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      fill_cnt_q     <= fill_cnt_d;
      out_valid_q    <= out_valid_d;
      pcm_out_q      <= pcm_out_d;
      active_steer_q <= active_steer_d;
      table_q        <= table_d;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.pcm_out      = pcm_out_q;
  assign bus.active_steer = active_steer_q;

`ifdef SUM_OUT_EN
  localparam int SUM_W = DATA_W + $clog2(NUM_CH);

  logic signed [SUM_W-1:0] sum_q, sum_d;
  logic                    sum_valid_q, sum_valid_d;

  // Sums the registered delayed samples, so the total trails out_valid by one cycle.
  always_comb begin
    logic signed [DATA_W-1:0] smp;
    logic signed [SUM_W-1:0]  acc;
    sum_d       = sum_q;
    sum_valid_d = out_valid_q;
    acc         = '0;
    smp         = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      smp = pcm_out_q[c*DATA_W +: DATA_W];
      acc = acc + SUM_W'(smp);
    end
    if (out_valid_q) begin
      sum_d = acc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  assign bus.sum_out   = sum_q;
  assign bus.sum_valid = sum_valid_q;
`endif

endmodule
